// File: rtl/digit_sequencer.sv
// Time-shares one 7-segment digit among FIFO-queued message digits: each digit
// is held for HOLD ticks, followed by GAP blank ticks; idle_digit shows when empty.
module digit_sequencer #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic       clk1s,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [3:0] idle_digit,
    output logic [3:0] digit,
    output logic       blank,
    output logic       dp,
    output logic       busy,
    output logic       msg_done
);
    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] TMR_ONE = CW'(1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit            GAP_EN  = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    state_t        state_q;
    logic [CW-1:0] tmr_q;
    logic [3:0]    digit_q;
    logic          blank_q;
    logic          dp_q;
    logic          busy_q;
    logic          msg_done_q;

    logic          have_s;
    logic          tmr_zero_s;
    logic          push_s;
    logic          pop_s;
    logic [4:0]    head_s;

    // Push/pop decisions and next FIFO count, all from registered state
    always_comb begin
        have_s     = (count_q != '0);
        tmr_zero_s = (tmr_q == '0);
        in_ready   = (count_q < DEPTH_C);
        push_s     = in_valid && in_ready && !clear;
        head_s     = mem_q[rd_ptr_q];
        pop_s      = 1'b0;
        if (!clear) begin
            case (state_q)
                ST_IDLE: pop_s = have_s;
                ST_SHOW: pop_s = tmr_zero_s && !GAP_EN && have_s;
                ST_GAP:  pop_s = tmr_zero_s && have_s;
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
        if (clear) begin
            count_d = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO storage; entries need no reset since count gates every read
    always_ff @(posedge clk1s) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_last, in_digit};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk1s or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Display sequencer FSM with registered outputs
    always_ff @(posedge clk1s or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            digit_q    <= 4'h0;
            blank_q    <= 1'b0;
            dp_q       <= 1'b0;
            busy_q     <= 1'b0;
            msg_done_q <= 1'b0;
        end else if (clear) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            digit_q    <= idle_digit;
            blank_q    <= 1'b0;
            dp_q       <= 1'b0;
            busy_q     <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            msg_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (have_s) begin
                        state_q <= ST_SHOW;
                        tmr_q   <= HOLD_LD;
                        digit_q <= head_s[3:0];
                        dp_q    <= head_s[4];
                        blank_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        digit_q <= idle_digit;
                        dp_q    <= 1'b0;
                        blank_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SHOW: begin
                    if (!tmr_zero_s) begin
                        tmr_q <= tmr_q - TMR_ONE;
                    end else begin
                        // dp still holds the last flag of the digit being retired
                        msg_done_q <= dp_q;
                        if (GAP_EN) begin
                            state_q <= ST_GAP;
                            tmr_q   <= GAP_LD;
                            blank_q <= 1'b1;
                            dp_q    <= 1'b0;
                        end else if (have_s) begin
                            tmr_q   <= HOLD_LD;
                            digit_q <= head_s[3:0];
                            dp_q    <= head_s[4];
                        end else begin
                            state_q <= ST_IDLE;
                            digit_q <= idle_digit;
                            dp_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (!tmr_zero_s) begin
                        tmr_q <= tmr_q - TMR_ONE;
                    end else if (have_s) begin
                        state_q <= ST_SHOW;
                        tmr_q   <= HOLD_LD;
                        digit_q <= head_s[3:0];
                        dp_q    <= head_s[4];
                        blank_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        digit_q <= idle_digit;
                        blank_q <= 1'b0;
                        dp_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tmr_q   <= '0;
                    digit_q <= idle_digit;
                    blank_q <= 1'b0;
                    dp_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign digit    = digit_q;
    assign blank    = blank_q;
    assign dp       = dp_q;
    assign busy     = busy_q;
    assign msg_done = msg_done_q;

endmodule
